// File: rtl/sc_fifo_reader_pkg.sv
// Shared types and helpers for the show-ahead FIFO burst reader: FSM state
// encoding, burst-length width and the burst-length clamp.
package sc_fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Bits needed to hold a word count from 0 up to and including burst.
  function automatic int len_width(input int burst);
    return $clog2(burst + 1);
  endfunction

  function automatic int min_len(input int usedw, input int burst);
    return (usedw < burst) ? usedw : burst;
  endfunction

endpackage

// File: rtl/sc_fifo_reader_timer.sv
// Saturating idle counter for the burst reader: counts while run is high,
// holds at TIMEOUT and flags expired; clear (or sclr) returns it to zero.
module sc_fifo_reader_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic sclr,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] count;

  always_ff @(posedge clock) begin
    if (sclr || clear) begin
      count <= '0;
    end else if (run && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/sc_fifo_burst_reader.sv
// Drain-side burst controller for a show-ahead single-clock FIFO. Optional
// partial-burst timeout is built when SC_FIFO_READER_TIMEOUT_EN is defined.
module sc_fifo_burst_reader
  import sc_fifo_reader_pkg::*;
#(
  parameter int LPM_WIDTH  = 16,
  parameter int LPM_WIDTHU = 4,
  parameter int BURST      = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                           clock,
  input  logic                           sclr,
  input  logic [LPM_WIDTH-1:0]           fifo_q,
  input  logic                           fifo_empty,
  input  logic [LPM_WIDTHU-1:0]          fifo_usedw,
  output logic                           fifo_rdreq,
  input  logic                           flush,
  output logic [LPM_WIDTH-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_first,
  output logic                           out_last,
  output logic [len_width(BURST)-1:0]    out_len,
  output logic                           busy
);

  localparam int LW = len_width(BURST);
  localparam int CW = (LW > LPM_WIDTHU) ? LW : LPM_WIDTHU;
  localparam logic [CW-1:0] BURST_C = CW'(BURST);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  state_t        state;
  state_t        state_next;
  logic [LW-1:0] remain;
  logic [LW-1:0] start_len;
  logic [CW-1:0] usedw_c;
  logic          has_data;
  logic          full;
  logic          part_req;
  logic          flush_pend;
  logic          first_pend;
  logic          timer_hit;
  logic          start;
  logic          pop;

  assign usedw_c   = CW'(fifo_usedw);
  assign has_data  = (usedw_c != '0);
  assign full      = (usedw_c >= BURST_C);
  assign start_len = LW'(min_len(int'(usedw_c), BURST));
  assign part_req  = flush_pend | flush | timer_hit;

`ifdef SC_FIFO_READER_TIMEOUT_EN
  logic timer_run;

  // Timer only runs while a partial burst is sitting in the FIFO.
  assign timer_run = (state == ST_IDLE) && has_data && !full;

  sc_fifo_reader_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .sclr    (sclr),
    .clear   (~timer_run),
    .run     (timer_run),
    .expired (timer_hit)
  );
`else
  // No timer in this build; the expression is constant false.
  assign timer_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_next = state;
    start      = 1'b0;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (full || (has_data && part_req)) begin
          start      = 1'b1;
          state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        pop = (~out_valid | out_ready) & ~fifo_empty & (remain != '0);
        if (pop && (remain == ONE_L)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid && out_ready && out_last) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fifo_rdreq = pop & ~sclr;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (sclr) begin
      state      <= ST_IDLE;
      remain     <= '0;
      out_len    <= '0;
      first_pend <= 1'b0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
    end else begin
      state <= state_next;

      // Partial-start requests are only remembered while idle.
      if (state == ST_IDLE) begin
        flush_pend <= start ? 1'b0 : (flush_pend | flush | timer_hit);
      end

      if (start) begin
        out_len    <= start_len;
        remain     <= start_len;
        first_pend <= 1'b1;
      end else if (pop) begin
        remain     <= remain - ONE_L;
        first_pend <= 1'b0;
      end

      if (pop) begin
        out_data  <= fifo_q;
        out_valid <= 1'b1;
        out_first <= first_pend;
        out_last  <= (remain == ONE_L);
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sc_fifo_burst_reader.sv
// Scoreboard bench for sc_fifo_burst_reader with a behavioural show-ahead
// FIFO; honours SC_FIFO_READER_TIMEOUT_EN for the timeout scenario.
module tb_sc_fifo_burst_reader;

  localparam int W  = 16;
  localparam int WU = 4;
  localparam int B  = 4;
  localparam int LW = 3;

  typedef struct packed {
    logic [W-1:0]  d;
    logic          f;
    logic          l;
    logic [LW-1:0] n;
  } exp_t;

  logic          clock = 1'b0;
  logic          sclr;
  logic [W-1:0]  fifo_q;
  logic          fifo_empty;
  logic [WU-1:0] fifo_usedw;
  logic          fifo_rdreq;
  logic          flush;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;
  logic [LW-1:0] out_len;
  logic          busy;

  logic          model_clr;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          force_empty;
  logic [W-1:0]  mem [0:15];
  logic [3:0]    rp;
  logic [3:0]    wp;
  logic [4:0]    cnt;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   pop_cnt = 0;

  always #5 clock = ~clock;

  sc_fifo_burst_reader #(
    .LPM_WIDTH  (W),
    .LPM_WIDTHU (WU),
    .BURST      (B),
    .TIMEOUT    (15)
  ) dut (
    .clock      (clock),
    .sclr       (sclr),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_usedw (fifo_usedw),
    .fifo_rdreq (fifo_rdreq),
    .flush      (flush),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_first  (out_first),
    .out_last   (out_last),
    .out_len    (out_len),
    .busy       (busy)
  );

  // Show-ahead FIFO model: head word always visible on fifo_q.
  assign fifo_q     = mem[rp];
  assign fifo_empty = (cnt == 5'd0) | force_empty;
  assign fifo_usedw = cnt[3:0];

  always @(posedge clock) begin
    if (model_clr) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp      <= wp + 4'd1;
      end
      if (fifo_rdreq) rp <= rp + 4'd1;
      cnt <= cnt + 5'(wr_en) - 5'(fifo_rdreq);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] d, input logic f, input logic l, input int n);
    exp_t e;
    e.d = d;
    e.f = f;
    e.l = l;
    e.n = LW'(n);
    exp_q.push_back(e);
  endtask

  task automatic exp_burst(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) push_exp(base + W'(i), i == 0, i == n - 1, n);
  endtask

  task automatic write_seq(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + W'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_busy(input string name, input int limit);
    int i;
    i = 0;
    while (!busy && i < limit) begin
      tick();
      i++;
    end
    if (!busy) check({name, "_start_timeout"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || busy) && i < limit) begin
      tick();
      i++;
    end
    check({name, "_drained"}, 32'(exp_q.size() == 0 && !busy), 32'd1);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock);
      if (!sclr) begin
        if (fifo_rdreq) pop_cnt++;
        if (out_valid && !out_ready) check("rdreq_while_stalled", 32'(fifo_rdreq), 32'd0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_word: actual %0h required none", out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 32'(out_data), 32'(e.d));
            check("out_first", 32'(out_first), 32'(e.f));
            check("out_last", 32'(out_last), 32'(e.l));
            check("out_len", 32'(out_len), 32'(e.n));
          end
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pb;
    int waited;
    logic quiet;
    logic [3:0] pat;

    sclr = 1'b1; model_clr = 1'b1; flush = 1'b0; out_ready = 1'b0;
    wr_en = 1'b0; wr_data = '0; force_empty = 1'b0;
    pat = 4'b1001;
    fork monitor(); join_none
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_first", 32'(out_first), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_len", 32'(out_len), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rdreq", 32'(fifo_rdreq), 0);
    sclr = 1'b0;
    model_clr = 1'b0;
    tick();

    // Full burst with latency checks
    out_ready = 1'b1;
    pb = pop_cnt;
    exp_burst(16'h1000, 4);
    write_seq(16'h1000, 4);
    wait_busy("full", 10);
    check("full_first_rdreq", 32'(fifo_rdreq), 1);
    check("full_valid_not_yet", 32'(out_valid), 0);
    tick();
    check("full_valid_next", 32'(out_valid), 1);
    check("full_first_flag", 32'(out_first), 1);
    wait_drain("full", 30);
    check("full_pops", 32'(pop_cnt - pb), 4);

    // Back-pressure: two bursts of 4 with ready 1,0,0,1
    pb = pop_cnt;
    out_ready = 1'b0;
    exp_burst(16'h2000, 4);
    exp_burst(16'h2004, 4);
    write_seq(16'h2000, 8);
    for (int i = 0; i < 80 && (exp_q.size() != 0 || busy); i++) begin
      out_ready = pat[i % 4];
      tick();
    end
    out_ready = 1'b1;
    wait_drain("bp", 30);
    check("bp_pops", 32'(pop_cnt - pb), 8);

    // Flush of a partial burst; flush mid-burst ignored
    write_seq(16'h3000, 3);
    repeat (5) tick();
    check("flush_idle_before", 32'(busy), 0);
    exp_burst(16'h3000, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_busy("flush", 5);
    flush = 1'b1;
    write_seq(16'h3100, 1);
    flush = 1'b0;
    wait_drain("flush", 30);
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (busy) quiet = 1'b0;
      tick();
    end
    check("flush_midburst_ignored", 32'(quiet), 1);
    exp_burst(16'h3100, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_drain("flush_single", 30);

    // Flush with empty FIFO stays pending until data arrives
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    check("flush_pending_idle", 32'(busy), 0);
    exp_burst(16'h3200, 1);
    write_seq(16'h3200, 1);
    wait_drain("flush_pending", 30);

    // Partial burst via timeout (or none without the timer)
    exp_burst(16'h4000, 2);
    write_seq(16'h4000, 2);
`ifdef SC_FIFO_READER_TIMEOUT_EN
    waited = 0;
    while (!busy && waited < 40) begin
      tick();
      waited++;
    end
    check("timeout_start_cycles", 32'(waited), 32'd15);
`else
    waited = 0;
    quiet = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (busy) quiet = 1'b0;
      tick();
    end
    check("no_timeout_burst", 32'(quiet), 32'(waited == 0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
`endif
    wait_drain("timeout", 40);

    // Reset after the second pop of a 4-word burst
    push_exp(16'h5000, 1'b1, 1'b0, 4);
    write_seq(16'h5000, 4);
    wait_busy("rstmid", 10);
    check("rstmid_pop1", 32'(fifo_rdreq), 1);
    tick();
    check("rstmid_pop2", 32'(fifo_rdreq), 1);
    tick();
    sclr = 1'b1;
    #1;
    check("rstmid_rdreq_in_sclr", 32'(fifo_rdreq), 0);
    tick();
    check("rstmid_valid", 32'(out_valid), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_rdreq", 32'(fifo_rdreq), 0);
    sclr = 1'b0;
    push_exp(16'h5002, 1'b1, 1'b0, 4);
    push_exp(16'h5003, 1'b0, 1'b0, 4);
    push_exp(16'h5100, 1'b0, 1'b0, 4);
    push_exp(16'h5101, 1'b0, 1'b1, 4);
    write_seq(16'h5100, 2);
    wait_drain("rstmid_after", 30);

    // Empty flag forced high mid-burst
    pb = pop_cnt;
    exp_burst(16'h6000, 4);
    write_seq(16'h6000, 4);
    wait_busy("stall", 10);
    tick();
    force_empty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_no_pop", 32'(fifo_rdreq), 0);
      tick();
    end
    force_empty = 1'b0;
    wait_drain("stall", 30);
    check("stall_pops", 32'(pop_cnt - pb), 4);

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
